uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side buffer and launch controller that feeds the 8N1 UART transmitter.
- Accepts bytes from the processor/bus side into a synchronous FIFO.
- Issues single-cycle start pulses to the transmitter, only coincident with a `uart_tick` pulse and only when the transmitter reports ready.
- Supports back-to-back frames: the next byte launches on the same tick that ends the previous stop bit.
- Provides occupancy and a sticky overflow flag for software polling.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2^DEPTH_LOG2 = 16 entries).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_tick  input  1  one-cycle baud-rate tick, shared with the transmitter.
- wr_data  input  8  byte to enqueue.
- wr_en  input  1  enqueue request; sampled every cycle.
- full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- overflow  output  1  sticky: a write was attempted while full.
- overflow_clr  input  1  clears overflow.
- tx_ready  input  1  transmitter ready (idle or in stop bit).
- tx_start  output  1  launch pulse to the transmitter.
- tx_data  output  8  byte to transmit; valid whenever tx_start=1.

Behaviour:
- Storage: 2^DEPTH_LOG2 x 8 array; write pointer, read pointer, and count registers. Pointers wrap modulo depth via natural DEPTH_LOG2-bit overflow.
- Reset: wr_ptr=0, rd_ptr=0, count=0, overflow=0, so empty=1, full=0, tx_start=0. Array contents are not reset; tx_data is don't-care while empty.
- Reset mid-frame drops every queued byte. The transmitter resets on the same reset, so no partial-state hazard exists.
- full = (count == 2^DEPTH_LOG2); empty = (count == 0). Both are derived combinationally from the registered count.
- Push: push = wr_en & ~full.
  - On push, mem[wr_ptr] <= wr_data and wr_ptr increments.
  - A write while full is dropped, even if a pop occurs the same cycle.
- Pop / launch: tx_start = uart_tick & tx_ready & ~empty (combinational). Pop occurs exactly when tx_start=1; rd_ptr increments.
  - tx_data = mem[rd_ptr] (first-word-fall-through).
  - The transmitter captures tx_data in the tx_start cycle, so the head may advance immediately.
- Start is only ever asserted with `uart_tick`, satisfying the transmitter's start-on-tick rule.
  - Launch latency from the first write into an empty FIFO is at least 1 clock (the byte is visible the cycle after the write edge), plus the wait for the next tick.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged (possible only when 0 < count < depth).
  - Push while empty plus a tick does not pop the new byte that cycle, because empty is registered.
- Overflow:
  - Set when wr_en & full.
  - Cleared when overflow_clr=1 and no new overflow occurs that cycle; set has priority over clear in the same cycle.
- tx_ready low: no pop and no start pulse; FIFO contents hold indefinitely.
- Ordering: bytes are transmitted strictly in write order. No byte is duplicated or skipped across pointer wrap.

Test Plan:
- Reset, then write 0x55 once, tx_ready=1 -> count 0->1; tx_start pulses for exactly one cycle, on the first uart_tick at least 1 cycle later, with tx_data=0x55; count returns to 0 and empty=1.
- Write 0x00..0x0F on 16 consecutive cycles with tx_ready=0 -> full=1, count=16; a 17th write of 0xAA is dropped and overflow=1. Pulse overflow_clr -> overflow=0, and contents are unchanged.
- From the full state, set tx_ready=1 with ticks every 10 clocks -> 16 start pulses, each on a tick, carrying tx_data 0x00..0x0F in order; empty is asserted after the last pulse.
- Pointer wrap: write and drain 24 bytes 0x10..0x27 interleaved -> transmitted order matches exactly across the wrap and count never exceeds 16.
- Count=5, wr_en=1 coincident with a tick and tx_ready=1 -> count stays 5, the head byte is launched, and the new byte is appended at the tail.
- With 3 bytes queued and wr_en and overflow_clr held, assert reset -> the following cycle has count=0, empty=1, overflow=0, and tx_start stays 0 on subsequent ticks.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that buffers bus writes and launches bytes into the 8N1 UART
// transmitter, one start pulse per baud tick while the transmitter is ready.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_tick,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clr,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_CNT   = (DEPTH_LOG2 + 1)'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign push     = wr_en & ~full;
    assign pop      = uart_tick & tx_ready & ~empty;
    assign tx_start = pop;
    assign tx_data  = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count define validity,
    // and leaving it out of reset lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            // A fresh overflow wins over a clear in the same cycle.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a negedge
// monitor checks every start pulse against the queue head.
module tb_uart_tx_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       uart_tick;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_starts = 0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_tick    (uart_tick),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .tx_ready     (tx_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Advance one clock; outputs are read 1ns after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Monitor: each start pulse must ride a tick with the transmitter ready and
    // carry the oldest outstanding byte.
    always @(negedge clock) begin
        if (tx_start === 1'b1) begin
            n_starts++;
            check("start_on_tick", int'(uart_tick), 1);
            check("start_when_ready", int'(tx_ready), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_start", int'(tx_data), -1);
            end else begin
                check("tx_data_order", int'(tx_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int max_count;

        reset = 1'b1; uart_tick = 1'b0; wr_data = 8'h00; wr_en = 1'b0;
        overflow_clr = 1'b0; tx_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        check("reset_count", int'(count), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_tx_start", int'(tx_start), 0);

        // Single byte launches on the first tick after it becomes visible.
        tx_ready = 1'b1; wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        cyc();
        wr_en = 1'b0;
        check("single_count_after_write", int'(count), 1);
        check("single_not_empty", int'(empty), 0);
        s0 = n_starts;
        for (int i = 0; i < 20; i++) begin
            uart_tick = (i % 5 == 4);
            cyc();
        end
        uart_tick = 1'b0;
        check("single_one_pulse", n_starts - s0, 1);
        check("single_count_drained", int'(count), 0);
        check("single_empty_drained", int'(empty), 1);

        // Fill to full with the transmitter busy, then overflow and clear.
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
            cyc();
        end
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 16);
        check("fill_no_overflow_yet", int'(overflow), 0);
        wr_data = 8'hAA;
        cyc();
        wr_en = 1'b0;
        check("overflow_set", int'(overflow), 1);
        check("overflow_count_held", int'(count), 16);
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        check("overflow_cleared", int'(overflow), 0);
        check("overflow_clr_count_held", int'(count), 16);

        // Drain the full FIFO with ticks every 10 clocks.
        tx_ready = 1'b1;
        s0 = n_starts;
        for (int i = 0; i < 170; i++) begin
            uart_tick = (i % 10 == 9);
            cyc();
        end
        uart_tick = 1'b0;
        check("drain_pulses", n_starts - s0, 16);
        check("drain_empty", int'(empty), 1);

        // Interleaved write/drain of 24 bytes across the pointer wrap.
        s0 = n_starts;
        max_count = 0;
        for (int i = 0; i < 24; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
            uart_tick = (i % 2 == 1);
            cyc();
            if (int'(count) > max_count) max_count = int'(count);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            uart_tick = (i % 2 == 1);
            cyc();
            if (int'(count) > max_count) max_count = int'(count);
        end
        uart_tick = 1'b0;
        check("wrap_pulses", n_starts - s0, 24);
        check("wrap_max_count_le_16", int'(max_count <= 16), 1);
        check("wrap_empty", int'(empty), 1);

        // Simultaneous push and pop at count 5.
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i); exp_q.push_back(8'(8'h30 + i));
            cyc();
        end
        check("pp_count_before", int'(count), 5);
        tx_ready = 1'b1; uart_tick = 1'b1; wr_data = 8'h35; exp_q.push_back(8'h35);
        s0 = n_starts;
        cyc();
        wr_en = 1'b0; uart_tick = 1'b0;
        check("pp_count_held", int'(count), 5);
        check("pp_one_launch", n_starts - s0, 1);
        for (int i = 0; i < 20; i++) begin
            uart_tick = (i % 3 == 2);
            cyc();
        end
        uart_tick = 1'b0;
        check("pp_drained", int'(empty), 1);

        // Reset with three bytes queued drops them all.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            cyc();
        end
        check("rst_queued", int'(count), 3);
        overflow_clr = 1'b1; reset = 1'b1;
        cyc();
        reset = 1'b0; wr_en = 1'b0; overflow_clr = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_overflow", int'(overflow), 0);
        tx_ready = 1'b1;
        s0 = n_starts;
        for (int i = 0; i < 20; i++) begin
            uart_tick = (i % 4 == 3);
            cyc();
        end
        uart_tick = 1'b0;
        check("rst_no_starts", n_starts - s0, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
